// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scan controller with a
// double-buffered digit register file, frame-aligned commit and inter-digit
// dead time. Optional blinking is compiled in with the macro SEG_BLINK_EN.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned DIV          = 50000,
    parameter int unsigned GUARD        = 16,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_blank,
`ifdef SEG_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [3:0]            dig_code,
    output logic [DIGITS-1:0]     an,
    output logic [2:0]            scan_idx,
    output logic                  frame_done
);

    localparam int unsigned MAXC   = (DIV > GUARD) ? DIV : GUARD;
    localparam int unsigned CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(DIGITS - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [2:0]          idx, idx_nxt;
    logic                boundary;

    logic [DATA_W-1:0]   act_data, act_data_nxt;
    logic [DIGITS-1:0]   act_blank, act_blank_nxt;
    logic [DATA_W-1:0]   pend_data, pend_data_nxt;
    logic [DIGITS-1:0]   pend_blank, pend_blank_nxt;
    logic                pend_vld, pend_vld_nxt;
    logic                accept, commit;

    logic [DIGITS-1:0]   sel;
    logic                blink_off;
    logic                lit;
    logic [DIGITS-1:0]   an_nxt;
    logic [3:0]          dig_code_nxt;
    logic                frame_done_nxt;

`ifdef SEG_BLINK_EN
    localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] BF_LAST = FC_W'(BLINK_FRAMES - 1);
    logic [FC_W-1:0]     fcnt, fcnt_nxt;
    logic                phase, phase_nxt;
`else
    logic                unused_blink_cfg;
    assign unused_blink_cfg = BLINK_FRAMES[0];
`endif

    // Next-state, buffer handshake/commit and look-ahead output decode
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CNT_W'(1);
        idx_nxt        = idx;
        boundary       = 1'b0;
        accept         = 1'b0;
        commit         = 1'b0;
        pend_data_nxt  = pend_data;
        pend_blank_nxt = pend_blank;
        pend_vld_nxt   = pend_vld;
        act_data_nxt   = act_data;
        act_blank_nxt  = act_blank;
        blink_off      = 1'b0;
        lit            = 1'b0;
        an_nxt         = '1;
`ifdef SEG_BLINK_EN
        fcnt_nxt       = fcnt;
        phase_nxt      = phase;
`endif

        case (state)
            ST_RUN: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                    if (idx == IDX_LAST) begin
                        idx_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt  = idx + 3'd1;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_RUN;
            end
        endcase

        // accept and commit are exclusive: one needs pend_vld low, the other high
        accept = wr_valid && !pend_vld;
        commit = boundary && pend_vld;
        if (accept) begin
            pend_data_nxt  = wr_data;
            pend_blank_nxt = wr_blank;
            pend_vld_nxt   = 1'b1;
        end else if (commit) begin
            pend_vld_nxt   = 1'b0;
        end
        if (commit) begin
            act_data_nxt  = pend_data;
            act_blank_nxt = pend_blank;
        end

        sel = DIGITS'(1) << idx_nxt;

`ifdef SEG_BLINK_EN
        if (boundary) begin
            if (fcnt == BF_LAST) begin
                fcnt_nxt  = '0;
                phase_nxt = ~phase;
            end else begin
                fcnt_nxt  = fcnt + FC_W'(1);
            end
        end
        blink_off = phase_nxt && ((blink_mask & sel) != '0);
`endif

        lit = (state_nxt == ST_RUN) && ((act_blank_nxt & sel) == '0) && !blink_off;
        if (lit) begin
            an_nxt = ~sel;
        end
        dig_code_nxt   = 4'(act_data_nxt >> {idx_nxt, 2'b00});
        frame_done_nxt = (state_nxt == ST_GUARD) && (cnt_nxt == GUARD_LAST) &&
                         (idx_nxt == IDX_LAST);
    end

    // Scan sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Active and pending digit buffers; reset leaves the display dark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data   <= '0;
            act_blank  <= '1;
            pend_data  <= '0;
            pend_blank <= '1;
            pend_vld   <= 1'b0;
        end else begin
            act_data   <= act_data_nxt;
            act_blank  <= act_blank_nxt;
            pend_data  <= pend_data_nxt;
            pend_blank <= pend_blank_nxt;
            pend_vld   <= pend_vld_nxt;
        end
    end

`ifdef SEG_BLINK_EN
    // Blink frame counter and phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else begin
            fcnt  <= fcnt_nxt;
            phase <= phase_nxt;
        end
    end
`endif

    // Output registers load the decode of the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            dig_code   <= 4'd0;
            scan_idx   <= 3'd0;
            frame_done <= 1'b0;
            wr_ready   <= 1'b1;
        end else begin
            an         <= an_nxt;
            dig_code   <= dig_code_nxt;
            scan_idx   <= idx_nxt;
            frame_done <= frame_done_nxt;
            wr_ready   <= !pend_vld_nxt;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller that shares a single `bcd7seg` decoder and segment bus among `DIGITS` common-anode digits. It holds the displayed nibbles in a double-buffered register file, takes updates over a valid/ready write port, and commits them only at frame boundaries so a frame never shows mixed old and new data. A dead-time blanking interval is inserted between digits to suppress ghosting. The block sits between the application logic and the board's shared seven-segment pins.

## Interface
- `DIGITS`, 8: number of digits scanned; range 2..8.
- `DIV`, 50000: clock cycles each digit is lit; must be at least 1.
- `GUARD`, 16: blank clock cycles between digits; must be at least 1.
- `BLINK_FRAMES`, 32: frames per blink half-period; only used with `SEG_BLINK_EN`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: pending buffer empty; a write is accepted on `wr_valid && wr_ready`.
- `wr_data` in 4*DIGITS: nibble i occupies bits [4i+3:4i].
- `wr_blank` in DIGITS: 1 blanks digit i.
- `blink_mask` in DIGITS: 1 makes digit i blink; present only with `SEG_BLINK_EN`.
- `dig_code` out 4: nibble for the current digit, wired to the decoder `b` input.
- `an` out DIGITS: digit enables, active-low; at most one bit is 0.
- `scan_idx` out 3: index of the current digit.
- `frame_done` out 1: one-cycle pulse at the frame boundary.

## Operation
- Registers:
  - active buffer: `act_data` and `act_blank`.
  - pending buffer: `pend_data`, `pend_blank` and `pend_vld`.
  - `cnt`, a cycle counter of width clog2(max(DIV, GUARD)).
  - `idx`, the digit index.
  - `state`, either RUN or GUARD.
- Write port:
  - The handshake loads the pending buffer and sets `pend_vld`.
  - `wr_ready = !pend_vld`.
  - While `wr_ready` is 0, `wr_valid` is ignored and input data may change freely.
- RUN:
  - `cnt` counts from 0 to DIV-1.
  - At DIV-1, the block clears `cnt` and moves to GUARD.
- GUARD:
  - `cnt` counts from 0 to GUARD-1.
  - At GUARD-1, the block clears `cnt`, advances `idx`, and returns to RUN.
  - `idx` wraps from DIGITS-1 to 0.
- Frame boundary (the GUARD exit with `idx == DIGITS-1`):
  - `frame_done` pulses.
  - If `pend_vld` is set, the pending buffer is copied to the active buffer and `pend_vld` is cleared.
- Write on the boundary cycle:
  - Commit uses pending contents registered before the clock edge.
  - If `pend_vld` was 0, the write is accepted into pending and committed at the next boundary, not the current one.
- Output drive:
  - `an[idx]` is 0 only in RUN when `act_blank[idx]` is 0 (and, with `SEG_BLINK_EN`, the digit is not in its blink-off phase).
  - `an` is all ones in GUARD.
  - `dig_code = act_data[idx]` at all times, including GUARD and blanked digits.
  - Every output is driven from registers; there is no combinational path from inputs to outputs.

## Timing
- Reset values:
  - `an` all ones.
  - `dig_code` 0.
  - `scan_idx` 0.
  - `frame_done` 0.
  - `wr_ready` 1.
  - `act_data` 0, `act_blank` all ones (display dark), `pend_vld` 0.
  - state RUN with `cnt` 0.
- Digit period is DIV+GUARD cycles; frame period is DIGITS*(DIV+GUARD) cycles.
- `wr_ready` drops the cycle after acceptance and rises the cycle after the commit.
- Write-to-display latency is at most 2 frames plus 1 cycle.
- The first digit is lit in the cycle after the commit edge.
- Reset asserted mid-frame returns all state, including both buffers, to the reset values immediately. Scan restarts at digit 0 after release.

## Configuration
- Macro `SEG_BLINK_EN`: enables blinking.
- Defined:
  - The `blink_mask` port exists.
  - A frame counter toggles `phase` every `BLINK_FRAMES` frames; `phase` resets to 0.
  - Digit i is forced dark in RUN when `blink_mask[i] && phase`.
  - The frame counter and `phase` reset on `rst_n`.
- Undefined: the port, the counter and `phase` are absent, and no blinking occurs.

## Test plan
All scenarios use DIGITS=4, DIV=4 and GUARD=2 (frame = 24 cycles).
- Reset check: hold reset, then release with no writes.
  - Required: `an` is 4'b1111 for all cycles and `frame_done` pulses every 24 cycles.
- Single write: write data 16'h4321, blank 0 at cycle 3.
  - Required: `wr_ready` is 0 from cycle 4 until the first boundary.
  - Required: the next frame shows `an` as 1110, 1101, 1011, 0111, each for 4 cycles with 2-cycle gaps of 1111.
  - Required: `dig_code` reads 1, 2, 3, 4 in that order.
- Backpressure: issue a second write 16'hABCD while `wr_ready` is 0.
  - Required: the write is ignored; the display stays 4321.
  - Required: a retry after `wr_ready` rises commits ABCD one boundary later.
- Boundary collision: write 16'h0F0F with `pend_vld` 0 exactly in the `frame_done` cycle.
  - Required: the current frame keeps its old data; 0F0F appears from the following frame.
- Blank mask: write blank 4'b0101.
  - Required: digits 0 and 2 keep `an` at 1 during their RUN slots while `dig_code` still cycles.
- Mid-frame reset, or blink (with `SEG_BLINK_EN`, BLINK_FRAMES=2, blink_mask 4'b0001):
  - Reset asserted mid-digit 2: outputs return to reset values at once.
  - Blink: digit 0 is dark in frames 2, 3, 6, 7 and lit in frames 0, 1, 4, 5.
